display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The module SHALL have parameter DIGIT_TICKS, default 64, meaning clock cycles per digit slot (legal range 4..256).
REQ-002 The module SHALL have parameter DEAD_TICKS, default 2, meaning cycles at the start of each slot with no digit enabled (legal range 1..DIGIT_TICKS-2).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-005 The module SHALL have port load, input, 1, a one-cycle strobe that captures value, blankMask and lzEn.
REQ-006 The module SHALL have port value, input, 16, four hex digits; [3:0] is digit 0, the least significant, and [15:12] is digit 3.
REQ-007 The module SHALL have port blankMask, input, 4; bit k=1 forces digit k dark.
REQ-008 The module SHALL have port lzEn, input, 1, which enables leading-zero suppression.
REQ-009 The module SHALL have port digitSel, output, 4, a one-hot active-high digit enable, or all zeros.
REQ-010 The module SHALL have port segments, output, 7, active-high gfedcba.
REQ-011 The module SHALL have port pending, output, 1, high while a captured load awaits the frame boundary.
REQ-012 The module SHALL have port frameStart, output, 1, a one-cycle pulse at each frame start.

Function
REQ-013 The module SHALL keep slot counter t and digit index d: t increments each cycle; when t==DIGIT_TICKS-1, t wraps to 0 and d advances 0->1->2->3->0.
REQ-014 The module SHALL treat the cycle with t==DIGIT_TICKS-1 and d==3 as the frame boundary.
REQ-015 On load, the module SHALL copy value, blankMask and lzEn into a pending register and set pending, except on a boundary cycle (REQ-017).
REQ-016 At a boundary with pending=1, the module SHALL copy the pending register into the active register and clear pending.
REQ-017 For a load on a boundary cycle, the module SHALL write the inputs directly to the active register; pending stays 0.
REQ-018 For a load while pending=1, the module SHALL overwrite the pending register; the last load before the boundary wins.
REQ-019 With lzEn active, the module SHALL suppress digit k (k=1..3) if it and all higher digits are 0; digit 0 is never suppressed.
REQ-020 The module SHALL treat a digit as dark when blanked or suppressed.
REQ-021 The module SHALL register digitSel, with one-cycle latency from (t,d): one-hot(d) if t>=DEAD_TICKS and digit d is not dark, else 4'b0000.
REQ-022 The module SHALL register segments with the same latency: the hex glyph of active digit d when digitSel is nonzero, else 7'b0000000.
REQ-023 The module SHALL use glyphs 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex).
REQ-024 The module SHALL pulse frameStart for one cycle on the cycle after each boundary.
REQ-025 The module SHALL never change the active register mid-frame (no tearing).

Reset
REQ-026 While rst is high, the module SHALL hold digitSel=0, segments=0, pending=0 and frameStart=0, and set t=0, d=0, active value=0, active blankMask=4'hF and active lzEn=0.
REQ-027 An assertion of rst mid-frame SHALL discard any pending load and take effect asynchronously.
REQ-028 After reset, all digits SHALL remain dark until the first load is applied.

Structure
REQ-029 A shared package display_pkg SHALL hold the glyph lookup constant, the DIGIT_TICKS/DEAD_TICKS defaults and the digit-count constant (4).
REQ-030 The slot counter SHALL be one counterParametric instance with COUNT=DIGIT_TICKS-1 and WIDTH=$clog2(DIGIT_TICKS); wrap is detected by comparison.

Verification (DIGIT_TICKS=8, DEAD_TICKS=2)
REQ-031 Reset with no load for 3 frames -> digitSel=0, segments=0 throughout; frameStart pulses every 32 cycles.
REQ-032 Load 16'h1234 with mask 0 mid-frame -> pending=1 until boundary; next frame: digit0 segments=66, digit1=4F, digit2=5B, digit3=06; digitSel=0 in cycles 0-1 of each slot.
REQ-033 lzEn=1 with value 16'h0007 -> only digit0 enabled, segments=07; value 16'h0000 -> only digit0, segments=3F.
REQ-034 Load 16'hABCD on a boundary cycle -> pending never rises; digit0 shows 5E in the next frame.
REQ-035 Loads 16'h1111 then 16'h2222 in one frame -> the next frame shows only 2 (5B) on all digits.
REQ-036 rst asserted mid-slot with pending=1 -> outputs 0 immediately; after release, digits stay dark and pending=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed hex display scanner: defaults,
// digit count, display configuration record and the hex glyph table.
package display_pkg;

    localparam int DIGIT_TICKS_DEF = 64;
    localparam int DEAD_TICKS_DEF  = 2;
    localparam int NUM_DIGITS      = 4;

    // Glyphs for 0..F, active-high gfedcba; digit n occupies bits [7n+6:7n].
    localparam logic [16*7-1:0] GLYPH_ROM = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  mask;
        logic        lz;
    } disp_cfg_t;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        return GLYPH_ROM[int'(nib)*7 +: 7];
    endfunction

endpackage

// File: rtl/counterParametric.sv
// Free-running up counter that wraps to zero after reaching COUNT.
module counterParametric #(
    parameter int COUNT = 7,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (count == WIDTH'(COUNT))
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed hex display scanner with frame-synchronous
// double-buffered loads, per-digit blanking and leading-zero suppression.
module display_scan
    import display_pkg::*;
#(
    parameter int DIGIT_TICKS = DIGIT_TICKS_DEF,
    parameter int DEAD_TICKS  = DEAD_TICKS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blankMask,
    input  logic        lzEn,
    output logic [3:0]  digitSel,
    output logic [6:0]  segments,
    output logic        pending,
    output logic        frameStart
);

    localparam int TW = $clog2(DIGIT_TICKS);
    localparam int DW = $clog2(NUM_DIGITS);

    logic [TW-1:0]         t;
    logic [DW-1:0]         d;
    logic                  wrap;
    logic                  boundary;
    logic                  lit;
    logic [NUM_DIGITS-1:0] dark;
    disp_cfg_t             act;
    disp_cfg_t             pend;
    disp_cfg_t             incoming;

    counterParametric #(
        .COUNT (DIGIT_TICKS - 1),
        .WIDTH (TW)
    ) slot_cnt (
        .clk   (clk),
        .rst   (rst),
        .count (t)
    );

    assign wrap     = (t == TW'(DIGIT_TICKS - 1));
    assign boundary = wrap && (d == DW'(NUM_DIGITS - 1));
    assign incoming = '{value: value, mask: blankMask, lz: lzEn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            d <= '0;
        else if (wrap)
            d <= d + 1'b1;
    end

    // A load landing on the boundary bypasses the pending buffer and wins
    // over any older pending value, so the next frame shows the newest data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act     <= '{value: '0, mask: '1, lz: 1'b0};
            pend    <= '{value: '0, mask: '1, lz: 1'b0};
            pending <= 1'b0;
        end else if (boundary) begin
            if (load)
                act <= incoming;
            else if (pending)
                act <= pend;
            pending <= 1'b0;
        end else if (load) begin
            pend    <= incoming;
            pending <= 1'b1;
        end
    end

    always_comb begin
        dark = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            dark[k] = act.mask[k];
            if (act.lz && (k != 0) && ((act.value >> (4 * k)) == '0))
                dark[k] = 1'b1;
        end
    end

    assign lit = (t >= TW'(DEAD_TICKS)) && !dark[d];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digitSel   <= '0;
            segments   <= '0;
            frameStart <= 1'b0;
        end else begin
            digitSel   <= lit ? (4'b0001 << d) : 4'b0000;
            segments   <= lit ? hex_glyph(act.value[{d, 2'b00} +: 4]) : 7'b0000000;
            frameStart <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed and random loads checked each cycle
// against a frame-number based model of what the display should show.
module tb_display_scan;

    localparam int DT = 8;
    localparam int DD = 2;
    localparam int FR = DT * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blankMask;
    logic        lzEn;
    logic [3:0]  digitSel;
    logic [6:0]  segments;
    logic        pending;
    logic        frameStart;

    always #5 clk = ~clk;

    display_scan #(
        .DIGIT_TICKS (DT),
        .DEAD_TICKS  (DD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blankMask  (blankMask),
        .lzEn       (lzEn),
        .digitSel   (digitSel),
        .segments   (segments),
        .pending    (pending),
        .frameStart (frameStart)
    );

    typedef struct {
        int          cyc;
        logic [15:0] v;
        logic [3:0]  m;
        logic        lz;
    } ld_t;

    ld_t         loads[$];
    int          k;
    int          total = 0;
    int          bad   = 0;
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // A load in cycle j becomes visible for the whole frame after frame j/FR.
    task automatic check_cycle();
        int          t = k % DT;
        int          d = (k / DT) % 4;
        int          f = k / FR;
        logic [15:0] v = 16'h0000;
        logic [3:0]  m = 4'hF;
        logic        lz = 1'b0;
        bit          pend = 0;
        int          top = 0;
        bit          on;
        logic [3:0]  nib;
        logic [3:0]  exp_sel;
        logic [6:0]  exp_seg;
        logic        exp_fs;
        foreach (loads[i]) begin
            if (loads[i].cyc / FR < f) begin
                v = loads[i].v; m = loads[i].m; lz = loads[i].lz;
            end else if (loads[i].cyc / FR == f && (k % FR) != FR - 1) begin
                pend = 1;
            end
        end
        for (int j = 0; j < 4; j++)
            if (v[4*j +: 4] != 4'h0) top = j;
        on      = (t >= DD) && !m[d] && !(lz && d > top);
        nib     = v[4*d +: 4];
        exp_sel = on ? 4'(1 << d) : 4'b0000;
        exp_seg = on ? glyph_tab[nib] : 7'h00;
        exp_fs  = ((k % FR) == FR - 1);
        total += 4;
        assert (digitSel === exp_sel) else begin
            bad++; $error("FAIL digitSel cyc=%0d got=%b exp=%b", k, digitSel, exp_sel);
        end
        assert (segments === exp_seg) else begin
            bad++; $error("FAIL segments cyc=%0d got=%h exp=%h", k, segments, exp_seg);
        end
        assert (pending === logic'(pend)) else begin
            bad++; $error("FAIL pending cyc=%0d got=%b exp=%b", k, pending, pend);
        end
        assert (frameStart === exp_fs) else begin
            bad++; $error("FAIL frameStart cyc=%0d got=%b exp=%b", k, frameStart, exp_fs);
        end
    endtask

    task automatic check_reset(input string tag);
        total += 4;
        assert (digitSel === 4'b0000) else begin
            bad++; $error("FAIL %s digitSel got=%b exp=0000", tag, digitSel);
        end
        assert (segments === 7'h00) else begin
            bad++; $error("FAIL %s segments got=%h exp=00", tag, segments);
        end
        assert (pending === 1'b0) else begin
            bad++; $error("FAIL %s pending got=%b exp=0", tag, pending);
        end
        assert (frameStart === 1'b0) else begin
            bad++; $error("FAIL %s frameStart got=%b exp=0", tag, frameStart);
        end
    endtask

    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] m, input logic lz);
        load = ld; value = v; blankMask = m; lzEn = lz;
        @(posedge clk);
        if (ld) loads.push_back('{k, v, m, lz});
        #1;
        check_cycle();
        k++;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 16'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic run_to(input int phase);
        while ((k % FR) != phase) idle(1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; blankMask = '0; lzEn = 1'b0;
        k = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check_reset("reset_hold");
        end
        rst = 1'b0;

        idle(3 * FR);

        run_to(10);
        step(1, 16'h1234, 4'h0, 1'b0);
        idle(2 * FR);

        run_to(5);
        step(1, 16'h0007, 4'h0, 1'b1);
        idle(2 * FR);
        run_to(5);
        step(1, 16'h0000, 4'h0, 1'b1);
        idle(2 * FR);

        run_to(FR - 1);
        step(1, 16'hABCD, 4'h0, 1'b0);
        idle(FR + 8);

        run_to(3);
        step(1, 16'h1111, 4'h0, 1'b0);
        idle(2);
        step(1, 16'h2222, 4'h0, 1'b0);
        idle(2 * FR);

        run_to(2);
        step(1, 16'h00F0, 4'b0100, 1'b1);
        idle(2 * FR);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom_range(0, 15) & 4'($urandom)),
                 1'($urandom));

        run_to(8);
        step(1, 16'h5A5A, 4'h0, 1'b0);
        idle(3);
        #1 rst = 1'b1;
        #1 check_reset("async_reset");
        @(posedge clk); #1;
        check_reset("reset_hold2");
        rst = 1'b0;
        k = 0;
        loads.delete();
        idle(2 * FR + 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
